// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall and forwarding controller for the 5-stage OTTER pipeline.
// A shift-register scoreboard tracks in-flight register writes past EX. It
// drives the stage enables and flushes, and the EX operand forward selects.
module pipe_hazard_ctrl #(
  parameter int unsigned RA_W      = 5,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned LOAD_LAT  = 2,
  parameter int unsigned CNT_W     = 32,
  localparam int unsigned SEL_W    = $clog2(FWD_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             imem_valid_i,
  input  logic             dmem_valid_i,
  input  logic [RA_W-1:0]  de_rs1_i,
  input  logic [RA_W-1:0]  de_rs2_i,
  input  logic             de_rs1_used_i,
  input  logic             de_rs2_used_i,
  input  logic             ex_valid_i,
  input  logic [RA_W-1:0]  ex_rs1_i,
  input  logic [RA_W-1:0]  ex_rs2_i,
  input  logic [RA_W-1:0]  ex_wa_i,
  input  logic             ex_reg_write_i,
  input  logic             ex_is_load_i,
  input  logic             br_taken_i,
  output logic             if_en_o,
  output logic             de_en_o,
  output logic             ex_en_o,
  output logic             mem_en_o,
  output logic             wb_en_o,
  output logic             de_flush_o,
  output logic             ex_flush_o,
  output logic [SEL_W-1:0] rs1_sel_o,
  output logic [SEL_W-1:0] rs2_sel_o,
  output logic [CNT_W-1:0] cnt_mem_stall_o,
  output logic [CNT_W-1:0] cnt_load_stall_o,
  output logic [CNT_W-1:0] cnt_squash_o
);

  // Bit p-1 of each vector describes scoreboard position p (1 = EX/MEM).
  logic [FWD_DEPTH-1:0]           sb_v_q;
  logic [FWD_DEPTH-1:0]           sb_ld_q;
  logic [FWD_DEPTH-1:0][RA_W-1:0] sb_wa_q;

  logic [CNT_W-1:0] cnt_mem_stall_q, cnt_load_stall_q, cnt_squash_q;

  logic mstall, luse, ex_writes;

  // Smallest (youngest) matching position wins; x0 never forwards.
  function automatic logic [SEL_W-1:0] fwd_sel(input logic [RA_W-1:0]                rs,
                                                input logic [FWD_DEPTH-1:0]           v,
                                                input logic [FWD_DEPTH-1:0][RA_W-1:0] wa);
    logic [SEL_W-1:0] sel;
    sel = '0;
    if (rs != '0) begin
      for (int p = FWD_DEPTH; p >= 1; p--) begin
        if (v[p-1] && wa[p-1] == rs) sel = SEL_W'(p);
      end
    end
    return sel;
  endfunction

  // Stall if the youngest producer of rs is a load whose data is not yet
  // forwardable by the time the consumer reaches EX.
  function automatic logic src_luse(input logic [RA_W-1:0]                rs,
                                    input logic                           used,
                                    input logic                           exw,
                                    input logic [RA_W-1:0]                exwa,
                                    input logic                           exld,
                                    input logic [FWD_DEPTH-1:0]           v,
                                    input logic [FWD_DEPTH-1:0][RA_W-1:0] wa,
                                    input logic [FWD_DEPTH-1:0]           ld);
    logic hit, haz;
    hit = 1'b0;
    haz = 1'b0;
    if (used && rs != '0) begin
      if (exw && exwa == rs) begin
        hit = 1'b1;
        haz = exld && (LOAD_LAT > 1);
      end
      for (int p = 1; p <= FWD_DEPTH; p++) begin
        if (!hit && v[p-1] && wa[p-1] == rs) begin
          hit = 1'b1;
          haz = ld[p-1] && ((p + 1) < int'(LOAD_LAT));
        end
      end
    end
    return haz;
  endfunction

  assign ex_writes = ex_valid_i & ex_reg_write_i;
  assign mstall    = ~(imem_valid_i & dmem_valid_i);
  assign rs1_sel_o = fwd_sel(ex_rs1_i, sb_v_q, sb_wa_q);
  assign rs2_sel_o = fwd_sel(ex_rs2_i, sb_v_q, sb_wa_q);
  assign luse = src_luse(de_rs1_i, de_rs1_used_i, ex_writes, ex_wa_i, ex_is_load_i,
                         sb_v_q, sb_wa_q, sb_ld_q)
              | src_luse(de_rs2_i, de_rs2_used_i, ex_writes, ex_wa_i, ex_is_load_i,
                         sb_v_q, sb_wa_q, sb_ld_q);

  // Prioritised enable/flush decode: memory stall, branch, load-use, run.
  always_comb begin
    if_en_o    = 1'b1;
    de_en_o    = 1'b1;
    ex_en_o    = 1'b1;
    mem_en_o   = 1'b1;
    wb_en_o    = 1'b1;
    de_flush_o = 1'b0;
    ex_flush_o = 1'b0;
    if (mstall) begin
      // A taken branch stays held in EX and is flushed once the stall clears.
      if_en_o  = 1'b0;
      de_en_o  = 1'b0;
      ex_en_o  = 1'b0;
      mem_en_o = 1'b0;
      wb_en_o  = 1'b0;
    end else if (br_taken_i) begin
      de_flush_o = 1'b1;
      ex_flush_o = 1'b1;
    end else if (luse) begin
      if_en_o    = 1'b0;
      de_en_o    = 1'b0;
      ex_flush_o = 1'b1;
    end
  end

  // Scoreboard shifts whenever the pipeline advances past EX.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb_v_q  <= '0;
      sb_ld_q <= '0;
      sb_wa_q <= '0;
    end else if (mem_en_o) begin
      for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
        sb_v_q[k]  <= sb_v_q[k-1];
        sb_ld_q[k] <= sb_ld_q[k-1];
        sb_wa_q[k] <= sb_wa_q[k-1];
      end
      sb_v_q[0]  <= ex_writes & (ex_wa_i != '0);
      sb_ld_q[0] <= ex_is_load_i;
      sb_wa_q[0] <= ex_wa_i;
    end
  end

  // Wrapping hazard event counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_mem_stall_q  <= '0;
      cnt_load_stall_q <= '0;
      cnt_squash_q     <= '0;
    end else if (mstall) begin
      cnt_mem_stall_q <= cnt_mem_stall_q + 1'b1;
    end else if (br_taken_i) begin
      cnt_squash_q <= cnt_squash_q + 1'b1;
    end else if (luse) begin
      cnt_load_stall_q <= cnt_load_stall_q + 1'b1;
    end
  end

  assign cnt_mem_stall_o  = cnt_mem_stall_q;
  assign cnt_load_stall_o = cnt_load_stall_q;
  assign cnt_squash_o     = cnt_squash_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with default parameters
// (FWD_DEPTH = 2, LOAD_LAT = 2). Expected values are hand-derived.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_valid, dmem_valid;
  logic [4:0] de_rs1, de_rs2;
  logic       de_rs1_used, de_rs2_used;
  logic       ex_valid;
  logic [4:0] ex_rs1, ex_rs2, ex_wa;
  logic       ex_reg_write, ex_is_load, br_taken;
  logic       if_en, de_en, ex_en, mem_en, wb_en, de_flush, ex_flush;
  logic [1:0] rs1_sel, rs2_sel;
  logic [31:0] cnt_mem_stall, cnt_load_stall, cnt_squash;

  int vectors = 0;
  int miscompares = 0;

  pipe_hazard_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .imem_valid_i    (imem_valid),
    .dmem_valid_i    (dmem_valid),
    .de_rs1_i        (de_rs1),
    .de_rs2_i        (de_rs2),
    .de_rs1_used_i   (de_rs1_used),
    .de_rs2_used_i   (de_rs2_used),
    .ex_valid_i      (ex_valid),
    .ex_rs1_i        (ex_rs1),
    .ex_rs2_i        (ex_rs2),
    .ex_wa_i         (ex_wa),
    .ex_reg_write_i  (ex_reg_write),
    .ex_is_load_i    (ex_is_load),
    .br_taken_i      (br_taken),
    .if_en_o         (if_en),
    .de_en_o         (de_en),
    .ex_en_o         (ex_en),
    .mem_en_o        (mem_en),
    .wb_en_o         (wb_en),
    .de_flush_o      (de_flush),
    .ex_flush_o      (ex_flush),
    .rs1_sel_o       (rs1_sel),
    .rs2_sel_o       (rs2_sel),
    .cnt_mem_stall_o (cnt_mem_stall),
    .cnt_load_stall_o(cnt_load_stall),
    .cnt_squash_o    (cnt_squash)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    br_taken    = 1'b0;
    de_rs1      = '0;
    de_rs2      = '0;
    de_rs1_used = 1'b0;
    de_rs2_used = 1'b0;
    ex_valid    = 1'b0;
    ex_rs1      = '0;
    ex_rs2      = '0;
    ex_wa       = '0;
    ex_reg_write = 1'b0;
    ex_is_load  = 1'b0;
  endtask

  task automatic set_ex(input logic [4:0] wa, input logic ld, input logic [4:0] r1,
                        input logic [4:0] r2);
    ex_valid     = 1'b1;
    ex_reg_write = 1'b1;
    ex_wa        = wa;
    ex_is_load   = ld;
    ex_rs1       = r1;
    ex_rs2       = r2;
  endtask

  task automatic set_de(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                        input logic u2);
    de_rs1      = r1;
    de_rs1_used = u1;
    de_rs2      = r2;
    de_rs2_used = u2;
  endtask

  initial begin
    rst        = 1'b1;
    imem_valid = 1'b1;
    dmem_valid = 1'b1;
    idle();
    tick();
    // Reset cycle: empty scoreboard, plain run decode.
    #1;
    chk("rst_if_en", 32'(if_en), 1);
    chk("rst_ex_flush", 32'(ex_flush), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_sel1", 32'(rs1_sel), 0);
    chk("rst_cnt_mem", cnt_mem_stall, 0);
    chk("rst_cnt_load", cnt_load_stall, 0);
    chk("rst_cnt_squash", cnt_squash, 0);

    // ALU back-to-back: add x5 in EX, sub x6,x5,x1 in DE.
    set_ex(5, 0, 0, 0);
    set_de(5, 1, 1, 1);
    #1;
    chk("alu_no_stall", 32'(de_en), 1);
    chk("alu_no_flush", 32'(ex_flush), 0);
    tick();
    idle();
    set_ex(6, 0, 5, 1);
    #1;
    chk("alu_rs1_sel", 32'(rs1_sel), 1);
    chk("alu_rs2_sel", 32'(rs2_sel), 0);
    tick();
    idle();
    tick();
    tick();

    // Load-use: lw x5 in EX, add x7,x5,x5 in DE.
    set_ex(5, 1, 0, 0);
    set_de(5, 1, 5, 1);
    #1;
    chk("lu_if_en", 32'(if_en), 0);
    chk("lu_de_en", 32'(de_en), 0);
    chk("lu_ex_en", 32'(ex_en), 1);
    chk("lu_ex_flush", 32'(ex_flush), 1);
    chk("lu_de_flush", 32'(de_flush), 0);
    tick();
    // Bubble in EX, load now at position 1; add still in DE.
    idle();
    set_de(5, 1, 5, 1);
    #1;
    chk("lu_release", 32'(if_en), 1);
    chk("lu_release_flush", 32'(ex_flush), 0);
    tick();
    idle();
    set_ex(7, 0, 5, 5);
    #1;
    chk("lu_rs1_sel", 32'(rs1_sel), 2);
    chk("lu_rs2_sel", 32'(rs2_sel), 2);
    chk("lu_cnt", cnt_load_stall, 1);
    tick();
    idle();
    tick();
    tick();

    // Load with one gap: lw x5, nop (writes x0), add x7,x5,x0.
    set_ex(5, 1, 0, 0);
    #1;
    chk("gap_ld_no_stall", 32'(if_en), 1);
    tick();
    idle();
    set_ex(0, 0, 0, 0);
    set_de(5, 1, 0, 1);
    #1;
    chk("gap_no_stall", 32'(de_en), 1);
    chk("gap_no_flush", 32'(ex_flush), 0);
    tick();
    idle();
    set_ex(7, 0, 5, 0);
    #1;
    chk("gap_rs1_sel", 32'(rs1_sel), 2);
    chk("gap_rs2_sel", 32'(rs2_sel), 0);
    tick();

    // x0 filter: lw x0 in EX, reader of x0 in DE; x7 remains at position 2.
    idle();
    set_ex(0, 1, 0, 0);
    set_de(0, 1, 0, 1);
    #1;
    chk("x0_no_stall", 32'(if_en), 1);
    tick();
    idle();
    set_ex(9, 0, 0, 7);
    #1;
    chk("x0_rs1_sel", 32'(rs1_sel), 0);
    chk("x7_rs2_sel", 32'(rs2_sel), 2);
    chk("x0_cnt_load", cnt_load_stall, 1);
    tick();
    idle();
    tick();
    tick();

    // Branch and load-use together: branch wins.
    set_ex(5, 1, 0, 0);
    set_de(5, 1, 5, 1);
    br_taken = 1'b1;
    #1;
    chk("br_de_flush", 32'(de_flush), 1);
    chk("br_ex_flush", 32'(ex_flush), 1);
    chk("br_if_en", 32'(if_en), 1);
    chk("br_de_en", 32'(de_en), 1);
    tick();
    idle();
    #1;
    chk("br_cnt_squash", cnt_squash, 1);
    chk("br_cnt_load", cnt_load_stall, 1);
    tick();
    tick();

    // Memory stall with a pending branch; x3 sits at position 1 throughout.
    set_ex(3, 0, 0, 0);
    tick();
    idle();
    set_ex(9, 0, 3, 0);
    br_taken   = 1'b1;
    dmem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ms_if_en", 32'(if_en), 0);
      chk("ms_mem_en", 32'(mem_en), 0);
      chk("ms_wb_en", 32'(wb_en), 0);
      chk("ms_de_flush", 32'(de_flush), 0);
      chk("ms_ex_flush", 32'(ex_flush), 0);
      chk("ms_sb_hold", 32'(rs1_sel), 1);
      tick();
    end
    dmem_valid = 1'b1;
    #1;
    chk("ms_rel_de_flush", 32'(de_flush), 1);
    chk("ms_rel_ex_flush", 32'(ex_flush), 1);
    chk("ms_rel_if_en", 32'(if_en), 1);
    chk("ms_cnt_mem", cnt_mem_stall, 3);
    tick();
    idle();
    #1;
    chk("ms_cnt_squash", cnt_squash, 2);

    // Reset during a memory stall clears everything.
    rst        = 1'b1;
    dmem_valid = 1'b0;
    tick();
    rst        = 1'b0;
    dmem_valid = 1'b1;
    ex_rs1     = 9;
    ex_rs2     = 3;
    #1;
    chk("post_rst_sel1", 32'(rs1_sel), 0);
    chk("post_rst_sel2", 32'(rs2_sel), 0);
    chk("post_rst_mem", cnt_mem_stall, 0);
    chk("post_rst_load", cnt_load_stall, 0);
    chk("post_rst_squash", cnt_squash, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
